if_fetch_unit: RTL
==================

// Module: if_fetch_unit
// PURPOSE
//  IF stage: owns the PC and fetches instructions from the instruction memory.
//  Sits directly upstream of the IF/ID pipeline register and drives its pc_if/inst_if inputs.
//  Runs a variable-latency request/response memory handshake, tolerates up to MAX_OUT requests
//  in flight, and buffers returned words in a small FIFO.
//  Handles branch redirects and discards stale responses.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset
//  FB_DEPTH  2              fetch-buffer entries (power of 2, >=2)
//  MAX_OUT   2              max outstanding imem requests (<= FB_DEPTH)
// PORTS
//  clk_cpu      in   1   single clock; all state updates on posedge
//  rst_cpu      in   1   reset, synchronous, active-high
//  redirect     in   1   branch/jump taken: restart fetch at redirect_pc
//  redirect_pc  in   32  new fetch target, word aligned
//  stop         in   1   hazard stall: IF/ID holds, do not pop the fetch buffer
//  imem_req     out  1   request valid
//  imem_addr    out  32  request word address
//  imem_ready   in   1   memory accepts the request this cycle (transfer = req & ready)
//  imem_rvalid  in   1   one in-order response word this cycle
//  imem_rdata   in   32  response instruction
//  pc_if        out  32  PC of the head instruction, or 32'hffff_fffc when there is none
//  inst_if      out  32  head instruction, or 32'h0 (bubble) when there is none
//  if_valid     out  1   head entry valid
// BEHAVIOUR
//  Reset (synchronous): state=BOOT, fetch_pc=resp_pc=RESET_PC, FIFO empty, out_cnt=drop_cnt=0.
//   imem_req=0, if_valid=0, inst_if=0, pc_if=32'hffff_fffc.
//  FSM: BOOT -> RUN after 1 cycle (no request in BOOT).
//   RUN -> DROP on redirect when the in-flight count after this cycle is >0; otherwise stay in RUN.
//   DROP -> RUN when drop_cnt reaches 0.
//   A redirect in DROP reloads drop_cnt and stays in DROP.
//  Issue: imem_req = (RUN|DROP) & !redirect & (out_cnt + fifo_cnt < FB_DEPTH) & (out_cnt < MAX_OUT).
//   imem_addr = fetch_pc. On transfer: fetch_pc += 4 and out_cnt++.
//  Response: each imem_rvalid decrements out_cnt.
//   If drop_cnt>0: the word is discarded and drop_cnt--.
//   Else {resp_pc, imem_rdata} is pushed and resp_pc += 4.
//   Credit rule guarantees the FIFO never overflows. Overflow is an assertion failure.
//  Output: combinational view of the FIFO head. When empty, show the bubble values above.
//   Pop when if_valid & !stop & !redirect. Push and pop in the same cycle are legal.
//   Latency: response cycle -> inst_if valid next cycle (1 register stage).
//  Redirect (priority over stop and over a same-cycle response):
//   - FIFO flushed; next-cycle outputs are the bubble.
//   - fetch_pc = resp_pc = redirect_pc.
//   - drop_cnt = out_cnt - imem_rvalid (the same-cycle response is also dropped).
//   - No request is issued in the redirect cycle.
//  Arithmetic: PC adds are 32-bit and wrap at 2^32 (0xffff_fffc + 4 = 0). out_cnt/drop_cnt are $clog2(MAX_OUT+1) bits.
//  rst_cpu mid-operation: everything returns to reset values next edge. Responses arriving while in BOOT are ignored.
//   The memory is also reset by rst_cpu, so no stale responses remain.
//  stop with a full FIFO: imem_req falls to 0 via credits; head is held stable.
// STRUCTURE
//  Shared pkg (riscv_pkg): RESET_PC default, BUBBLE_INST=32'h0, BUBBLE_PC=32'hffff_fffc, fetch state enum {BOOT,RUN,DROP}.
//  Sub-module fetch_fifo:
//   - parameterised depth/width (64-bit {pc,inst}), synchronous flush.
//   - push/pop, count, empty/full.
//   - reused later for the decode queue.
//  Top holds the FSM, PC registers, counters and the issue logic.
// TESTING
//  1 Reset release, imem_ready=1, rvalid 1 cycle after each accept:
//    -> first imem_addr=0x0 in cycle 2, then 0x4, 0x8.
//    -> inst_if follows the returned words with pc_if=0x0, 0x4, ...
//  2 Memory latency 3, stop=0:
//    -> out_cnt never exceeds 2 and imem_req drops while 2 are outstanding.
//    -> if_valid pattern matches the response cadence; no lost or duplicated PC.
//  3 redirect to 0x100 with 2 requests outstanding (0x8, 0xC):
//    -> both responses are discarded and state passes through DROP.
//    -> next visible instruction is pc_if=0x100.
//  4 stop=1 for 5 cycles with FIFO full:
//    -> imem_req=0 and pc_if/inst_if stay stable.
//    -> on stop=0, entries pop in order.
//  5 redirect and stop in the same cycle, plus a same-cycle rvalid:
//    -> redirect wins, FIFO is flushed, and that response is dropped (drop_cnt excludes it).
//  6 rst_cpu asserted mid-stream with 2 outstanding:
//    -> next cycle outputs are bubble, imem_req=0, state=BOOT.
//    -> fetch restarts at 0x0; PC wrap check from 0xffff_fff8 gives 0xffff_fffc then 0x0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end: reset/bubble constants, fetch FSM states
// and the {pc, inst} entry carried through the fetch buffer.
package riscv_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] BUBBLE_INST      = 32'h0000_0000;
  localparam logic [31:0] BUBBLE_PC        = 32'hffff_fffc;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // PC increment wraps naturally at 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush, used as the fetch buffer (and later the decode queue).
// The head word is presented combinationally on rd_data.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wr_data,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full buffer is only taken when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: owns the PC, issues credit-limited requests to instruction memory, buffers
// in-order responses and discards the ones made stale by a redirect.
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          FB_DEPTH = 2,
  parameter int          MAX_OUT  = 2
) (
  input  logic        clk_cpu,
  input  logic        rst_cpu,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stop,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_if,
  output logic [31:0] inst_if,
  output logic        if_valid
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int FW = $clog2(FB_DEPTH + 1);

  fetch_state_e  state;
  fetch_state_e  state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] out_cnt_next;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] drop_cnt_next;

  logic          active;
  logic          redirect_act;
  logic          resp_act;
  logic          transfer;
  logic          fifo_push;
  logic          fifo_pop;
  logic [FW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  fetch_entry_t  head;
  fetch_entry_t  wr_entry;

  assign imem_addr = fetch_pc;
  assign wr_entry  = '{pc: resp_pc, inst: imem_rdata};
  assign if_valid  = !fifo_empty;
  assign pc_if     = fifo_empty ? BUBBLE_PC   : head.pc;
  assign inst_if   = fifo_empty ? BUBBLE_INST : head.inst;

  always_ff @(posedge clk_cpu) begin
    if (rst_cpu) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      out_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      state    <= state_next;
      out_cnt  <= out_cnt_next;
      drop_cnt <= drop_cnt_next;
      if (redirect_act) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
      end else begin
        if (transfer)  fetch_pc <= next_pc(fetch_pc);
        if (fifo_push) resp_pc  <= next_pc(resp_pc);
      end
    end
  end

  // Credits count both words in flight and words already buffered, so every
  // accepted request is guaranteed a FIFO slot when its response returns.
  always_comb begin
    state_next    = state;
    active        = (state != BOOT);
    redirect_act  = redirect && active;
    resp_act      = imem_rvalid && active;
    imem_req      = active && !redirect
                    && ((int'(out_cnt) + int'(fifo_count)) < FB_DEPTH)
                    && (int'(out_cnt) < MAX_OUT);
    transfer      = imem_req && imem_ready;
    fifo_push     = resp_act && !redirect && (drop_cnt == '0);
    fifo_pop      = if_valid && !stop && !redirect;
    out_cnt_next  = out_cnt + CW'(transfer) - CW'(resp_act);
    drop_cnt_next = drop_cnt;

    if (redirect_act) begin
      drop_cnt_next = out_cnt_next;
    end else if (resp_act && (drop_cnt != '0)) begin
      drop_cnt_next = drop_cnt - CW'(1);
    end

    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (redirect && (out_cnt_next != '0)) state_next = DROP;
      end
      DROP: begin
        if (drop_cnt_next == '0) state_next = RUN;
      end
      default: state_next = BOOT;
    endcase
  end

  fetch_fifo #(
    .DEPTH (FB_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk     (clk_cpu),
    .rst     (rst_cpu),
    .flush   (redirect_act),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wr_data (wr_entry),
    .rd_data (head),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge clk_cpu) begin
    if (!rst_cpu) assert (!(fifo_push && fifo_full && !fifo_pop));
  end

endmodule
